// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants, types and header table for the ILI9488 fill path.
// Holds command opcodes, COLMOD values, pixel-format and FSM enums, panel defaults.
// hdr_entry() maps a 4-bit header index to {D/CX, byte} for the window preamble.
package lcd_pkg;

  // ILI9488 command opcodes
  localparam logic [7:0] CMD_COLMOD = 8'h3A;
  localparam logic [7:0] CMD_CASET  = 8'h2A;
  localparam logic [7:0] CMD_PASET  = 8'h2B;
  localparam logic [7:0] CMD_RAMWR  = 8'h2C;

  // COLMOD parameter values
  localparam logic [7:0] COLMOD_565 = 8'h55;
  localparam logic [7:0] COLMOD_666 = 8'h66;

  // Default panel geometry
  localparam int DEF_H_RES = 320;
  localparam int DEF_V_RES = 480;

  typedef enum logic {
    FMT_565 = 1'b0,
    FMT_666 = 1'b1
  } pix_fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PIX,
    ST_FIN
  } fill_state_e;

  // Header entry lookup: returns {data_command, data_out}.
  function automatic logic [8:0] hdr_entry(
    input logic [3:0]  idx,
    input pix_fmt_e    fmt,
    input logic [15:0] xs,
    input logic [15:0] xe,
    input logic [15:0] ys,
    input logic [15:0] ye
  );
    logic [8:0] e;
    case (idx)
      4'd0:    e = {1'b0, CMD_COLMOD};
      4'd1:    e = {1'b1, (fmt == FMT_666) ? COLMOD_666 : COLMOD_565};
      4'd2:    e = {1'b0, CMD_CASET};
      4'd3:    e = {1'b1, xs[15:8]};
      4'd4:    e = {1'b1, xs[7:0]};
      4'd5:    e = {1'b1, xe[15:8]};
      4'd6:    e = {1'b1, xe[7:0]};
      4'd7:    e = {1'b0, CMD_PASET};
      4'd8:    e = {1'b1, ys[15:8]};
      4'd9:    e = {1'b1, ys[7:0]};
      4'd10:   e = {1'b1, ye[15:8]};
      4'd11:   e = {1'b1, ye[7:0]};
      4'd12:   e = {1'b0, CMD_RAMWR};
      default: e = {1'b0, 8'h00};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/lcd_rect_fill_if.sv
// lcd_rect_fill_if: byte stream from the fill engine to the serializer/bus driver.
// Latency: none (wires only). Backpressure: byte moves when data_valid & data_ready.
// Ports: data_out/data_command (D/CX)/data_valid/disp_cs from master, data_ready from slave.
interface lcd_rect_fill_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       data_command;
  logic       disp_cs;

  modport master (
    output data_out,
    output data_valid,
    output data_command,
    output disp_cs,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  data_command,
    input  disp_cs,
    output data_ready
  );
endinterface

// File: rtl/lcd_pixel_encoder.sv
// lcd_pixel_encoder: maps (color, pix_fmt, byte index) to one bus byte.
// Latency: combinational. Backpressure: none; the caller owns the byte index.
// Ports: color (RGB565), pix_fmt, byte_idx (0..1 for 565, 0..2 for 666) -> byte_out.
module lcd_pixel_encoder
  import lcd_pkg::*;
(
  input  logic [15:0] color,
  input  pix_fmt_e    pix_fmt,
  input  logic [1:0]  byte_idx,
  output logic [7:0]  byte_out
);

  logic [4:0] r5;
  logic [5:0] g6;
  logic [4:0] b5;

  assign r5 = color[15:11];
  assign g6 = color[10:5];
  assign b5 = color[4:0];

  // 666 widens 5-bit channels by replicating the MSB, then left-aligns in the byte.
  always_comb begin
    byte_out = 8'h00;
    if (pix_fmt == FMT_565) begin
      byte_out = (byte_idx == 2'd0) ? color[15:8] : color[7:0];
    end else begin
      case (byte_idx)
        2'd0:    byte_out = {r5, r5[4], 2'b00};
        2'd1:    byte_out = {g6, 2'b00};
        default: byte_out = {b5, b5[4], 2'b00};
      endcase
    end
  end

endmodule

// File: rtl/lcd_rect_fill.sv
// lcd_rect_fill: emits COLMOD/CASET/PASET/RAMWR header then a solid-colour window fill.
// Latency: first byte valid 1 cycle after accepted start; done 1 cycle after last byte.
// Backpressure: byte held stable while data_valid & !data_ready; 1 byte/cycle when ready.
// Ports: clk, rst_n, init_done, start, x0/x1/y0/y1, color, pix_fmt in; bus (byte stream
//        master), busy, done (completion pulse), err (rejected-request pulse) out.
module lcd_rect_fill
  import lcd_pkg::*;
#(
  parameter int H_RES   = DEF_H_RES,
  parameter int V_RES   = DEF_V_RES,
  parameter int COORD_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init_done,
  input  logic               start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] y1,
  input  logic [15:0]        color,
  input  logic               pix_fmt,
  lcd_rect_fill_if.master    bus,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int PCW = $clog2(H_RES * V_RES + 1);
  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_RES - 1);
  localparam logic [3:0]         HDR_LAST = 4'd12;

  fill_state_e      state_q, state_d;
  logic [3:0]       hdr_idx_q, hdr_idx_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [PCW-1:0]   pix_cnt_q, pix_cnt_d;
  logic [15:0]      xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [15:0]      color_q, color_d;
  pix_fmt_e         fmt_q, fmt_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             data_command_q, data_command_d;
  logic             disp_cs_q, disp_cs_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             fire;
  logic             req_bad;
  logic             byte_last;
  logic [PCW-1:0]   win_w, win_h;
  logic [2*PCW-1:0] win_area;
  logic [PCW-1:0]   npix_m1;
  logic [8:0]       hdr_next;
  logic [1:0]       enc_idx;
  logic [7:0]       enc_byte;

  assign fire    = data_valid_q & bus.data_ready;
  assign req_bad = (x0 > x1) | (y0 > y1) | (x1 > X_LAST) | (y1 > Y_LAST);

  // Pixel count minus one, from the raw inputs; only used when the request is valid.
  assign win_w    = PCW'(x1) - PCW'(x0) + PCW'(1);
  assign win_h    = PCW'(y1) - PCW'(y0) + PCW'(1);
  assign win_area = (2*PCW)'(win_w) * (2*PCW)'(win_h);
  assign npix_m1  = PCW'(win_area) - PCW'(1);

  assign byte_last = (fmt_q == FMT_666) ? (byte_idx_q == 2'd2) : (byte_idx_q == 2'd1);
  assign hdr_next  = hdr_entry(hdr_idx_q + 4'd1, fmt_q, xs_q, xe_q, ys_q, ye_q);

  // Index of the pixel byte to load next: restart at 0 on a new pixel (or entering PIX).
  assign enc_idx = ((state_q == ST_PIX) && !byte_last) ? (byte_idx_q + 2'd1) : 2'd0;

  lcd_pixel_encoder u_enc (
    .color    (color_q),
    .pix_fmt  (fmt_q),
    .byte_idx (enc_idx),
    .byte_out (enc_byte)
  );

  always_comb begin
    state_d        = state_q;
    hdr_idx_d      = hdr_idx_q;
    byte_idx_d     = byte_idx_q;
    pix_cnt_d      = pix_cnt_q;
    xs_d           = xs_q;
    xe_d           = xe_q;
    ys_d           = ys_q;
    ye_d           = ye_q;
    color_d        = color_q;
    fmt_d          = fmt_q;
    data_out_d     = data_out_q;
    data_valid_d   = data_valid_q;
    data_command_d = data_command_q;
    disp_cs_d      = disp_cs_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    err_d          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && init_done) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            xs_d           = 16'(x0);
            xe_d           = 16'(x1);
            ys_d           = 16'(y0);
            ye_d           = 16'(y1);
            color_d        = color;
            fmt_d          = pix_fmt_e'(pix_fmt);
            pix_cnt_d      = npix_m1;
            hdr_idx_d      = 4'd0;
            byte_idx_d     = 2'd0;
            // Header byte 0 is always COLMOD, so it can be loaded before the latch.
            data_out_d     = CMD_COLMOD;
            data_command_d = 1'b0;
            data_valid_d   = 1'b1;
            disp_cs_d      = 1'b0;
            busy_d         = 1'b1;
            state_d        = ST_HDR;
          end
        end
      end

      ST_HDR: begin
        if (fire) begin
          if (hdr_idx_q == HDR_LAST) begin
            byte_idx_d     = 2'd0;
            data_out_d     = enc_byte;
            data_command_d = 1'b1;
            state_d        = ST_PIX;
          end else begin
            hdr_idx_d                    = hdr_idx_q + 4'd1;
            {data_command_d, data_out_d} = hdr_next;
          end
        end
      end

      ST_PIX: begin
        if (fire) begin
          if (byte_last && (pix_cnt_q == '0)) begin
            // Last byte gone: next cycle is FIN with the bus released.
            data_valid_d = 1'b0;
            disp_cs_d    = 1'b1;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            state_d      = ST_FIN;
          end else if (byte_last) begin
            pix_cnt_d  = pix_cnt_q - PCW'(1);
            byte_idx_d = 2'd0;
            data_out_d = enc_byte;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            data_out_d = enc_byte;
          end
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      hdr_idx_q      <= 4'd0;
      byte_idx_q     <= 2'd0;
      pix_cnt_q      <= '0;
      xs_q           <= 16'h0000;
      xe_q           <= 16'h0000;
      ys_q           <= 16'h0000;
      ye_q           <= 16'h0000;
      color_q        <= 16'h0000;
      fmt_q          <= FMT_565;
      data_out_q     <= 8'h00;
      data_valid_q   <= 1'b0;
      data_command_q <= 1'b0;
      disp_cs_q      <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      hdr_idx_q      <= hdr_idx_d;
      byte_idx_q     <= byte_idx_d;
      pix_cnt_q      <= pix_cnt_d;
      xs_q           <= xs_d;
      xe_q           <= xe_d;
      ys_q           <= ys_d;
      ye_q           <= ye_d;
      color_q        <= color_d;
      fmt_q          <= fmt_d;
      data_out_q     <= data_out_d;
      data_valid_q   <= data_valid_d;
      data_command_q <= data_command_d;
      disp_cs_q      <= disp_cs_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.data_valid   = data_valid_q;
  assign bus.data_command = data_command_q;
  assign bus.disp_cs      = disp_cs_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;

endmodule

// File: tb/tb_lcd_rect_fill.sv
// tb_lcd_rect_fill: directed bench for lcd_rect_fill with hand-computed byte streams.
// Latency: checks first byte at T+1, done at last-byte+1, idle at last-byte+2.
// Backpressure: exercises random data_ready throttling and byte stability while stalled.
module tb_lcd_rect_fill;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done = 1'b0;
  logic        start = 1'b0;
  logic [15:0] x0 = '0, x1 = '0, y0 = '0, y1 = '0;
  logic [15:0] color = '0;
  logic        pix_fmt = 1'b0;
  logic        busy, done, err;

  lcd_rect_fill_if bus();

  lcd_rect_fill #(.H_RES(320), .V_RES(480), .COORD_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done),
    .start     (start),
    .x0        (x0),
    .x1        (x1),
    .y0        (y0),
    .y1        (y1),
    .color     (color),
    .pix_fmt   (pix_fmt),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Monitor state (written only by the monitor process).
  int         cyc = 0;
  logic [8:0] got[$];
  int         last_xfer_cyc = 0, done_cyc = 0, done_cnt = 0, err_cnt = 0;
  int         cs_bad = 0, stall_bad = 0, valid_seen = 0;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_byte = '0;

  logic [8:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) begin
      valid_seen++;
      if (bus.disp_cs !== 1'b0) cs_bad++;
    end
    if (prev_stall && ((bus.data_valid !== 1'b1) || ({bus.data_command, bus.data_out} !== prev_byte)))
      stall_bad++;
    prev_stall = (bus.data_valid === 1'b1) && (bus.data_ready === 1'b0) && rst_n;
    prev_byte  = {bus.data_command, bus.data_out};
    if (bus.data_valid === 1'b1 && bus.data_ready === 1'b1) begin
      got.push_back({bus.data_command, bus.data_out});
      last_xfer_cyc = cyc;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      if (bus.disp_cs !== 1'b1) cs_bad++;
    end
    if (err === 1'b1) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] b0,
                         input logic [15:0] b1, input logic [15:0] c, input logic f);
    x0 = a0; x1 = a1; y0 = b0; y1 = b1; color = c; pix_fmt = f;
  endtask

  // Leaves the bench at T+1 plus #1, where T is the cycle start was high.
  task automatic pulse_start();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  // Returns at L+2 plus #1 when done fires; optional random throttling.
  task automatic wait_done(input string tag, input int budget, input bit throttle);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk); #1;
      if (throttle) bus.data_ready = 1'($urandom_range(0, 1));
      n++;
    end
    bus.data_ready = 1'b1;
    chk({tag, "_done_seen"}, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic cmp_stream(input string tag, input int base);
    chk({tag, "_len"}, 32'(got.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && (base + i) < got.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(got[base + i]), 32'(exp_q[i]));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cs"}, 32'(bus.disp_cs), 32'd1);
    chk({tag, "_valid"}, 32'(bus.data_valid), 32'd0);
  endtask

  initial begin
    int base, vs0, ec0, dc0, cs0, sb0;

    bus.data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_data_out", 32'(bus.data_out), 32'h00);
    chk("rst_valid", 32'(bus.data_valid), 32'd0);
    chk("rst_dcx", 32'(bus.data_command), 32'd0);
    chk("rst_cs", 32'(bus.disp_cs), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk); rst_n = 1'b1; init_done = 1'b1;

    // Test 1: 1x1 at (0,0), RGB565, 0xF800
    cs0 = cs_bad;
    base = got.size();
    set_req(16'd0, 16'd0, 16'd0, 16'd0, 16'hF800, 1'b0);
    pulse_start();
    chk("t1_first_busy", 32'(busy), 32'd1);
    chk("t1_first_cs", 32'(bus.disp_cs), 32'd0);
    chk("t1_first_valid", 32'(bus.data_valid), 32'd1);
    chk("t1_first_byte", 32'({bus.data_command, bus.data_out}), 32'h03A);
    wait_done("t1", 200, 1'b0);
    chk_idle("t1_end");
    chk("t1_done_lat", 32'(done_cyc - last_xfer_cyc), 32'd1);
    chk("t1_cs_low", 32'(cs_bad - cs0), 32'd0);
    exp_q = '{9'h03A, 9'h155, 9'h02A, 9'h100, 9'h100, 9'h100, 9'h100, 9'h02B,
              9'h100, 9'h100, 9'h100, 9'h100, 9'h02C, 9'h1F8, 9'h100};
    cmp_stream("t1", base);

    // Test 2: x 318..319, y 477..479, RGB666, 0x07E0
    base = got.size();
    set_req(16'd318, 16'd319, 16'd477, 16'd479, 16'h07E0, 1'b1);
    pulse_start();
    wait_done("t2", 300, 1'b0);
    exp_q = '{9'h03A, 9'h166, 9'h02A, 9'h101, 9'h13E, 9'h101, 9'h13F, 9'h02B,
              9'h101, 9'h1DD, 9'h101, 9'h1DF, 9'h02C};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(9'h100); exp_q.push_back(9'h1FC); exp_q.push_back(9'h100);
    end
    cmp_stream("t2", base);
    chk("t2_done_lat", 32'(done_cyc - last_xfer_cyc), 32'd1);

    // Test 3: 4x4 RGB565 with random throttling
    base = got.size();
    sb0 = stall_bad;
    set_req(16'd2, 16'd5, 16'd10, 16'd13, 16'h1234, 1'b0);
    pulse_start();
    wait_done("t3", 2000, 1'b1);
    exp_q = '{9'h03A, 9'h155, 9'h02A, 9'h100, 9'h102, 9'h100, 9'h105, 9'h02B,
              9'h100, 9'h10A, 9'h100, 9'h10D, 9'h02C};
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(9'h112); exp_q.push_back(9'h134);
    end
    cmp_stream("t3", base);
    chk("t3_stall_stable", 32'(stall_bad - sb0), 32'd0);

    // Test 4: rejected requests (x0 > x1, then y1 = 480)
    vs0 = valid_seen;
    set_req(16'd5, 16'd4, 16'd0, 16'd0, 16'hFFFF, 1'b0);
    pulse_start();
    chk("t4a_err", 32'(err), 32'd1);
    chk_idle("t4a");
    @(posedge clk); #1;
    chk("t4a_err_pulse", 32'(err), 32'd0);
    set_req(16'd0, 16'd0, 16'd0, 16'd480, 16'hFFFF, 1'b0);
    pulse_start();
    chk("t4b_err", 32'(err), 32'd1);
    chk_idle("t4b");
    repeat (3) @(posedge clk); #1;
    chk("t4_no_valid", 32'(valid_seen - vs0), 32'd0);

    // Test 5a: start with init_done low
    ec0 = err_cnt;
    init_done = 1'b0;
    set_req(16'd0, 16'd0, 16'd0, 16'd0, 16'h1111, 1'b0);
    pulse_start();
    chk("t5a_err", 32'(err), 32'd0);
    chk_idle("t5a");
    init_done = 1'b1;

    // Test 5b: start pulsed mid-transfer with different (even invalid) inputs
    base = got.size();
    dc0 = done_cnt;
    set_req(16'd7, 16'd8, 16'd0, 16'd1, 16'hABCD, 1'b0);
    pulse_start();
    repeat (4) @(posedge clk);
    set_req(16'd0, 16'd400, 16'd3, 16'd3, 16'h5555, 1'b1);
    pulse_start();
    chk("t5b_mid_err", 32'(err), 32'd0);
    chk("t5b_mid_busy", 32'(busy), 32'd1);
    wait_done("t5b", 300, 1'b0);
    exp_q = '{9'h03A, 9'h155, 9'h02A, 9'h100, 9'h107, 9'h100, 9'h108, 9'h02B,
              9'h100, 9'h100, 9'h100, 9'h101, 9'h02C};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(9'h1AB); exp_q.push_back(9'h1CD);
    end
    cmp_stream("t5b", base);
    chk("t5_err_count", 32'(err_cnt - ec0), 32'd0);
    chk("t5_done_count", 32'(done_cnt - dc0), 32'd1);

    // Test 6: reset during PIX, then a fresh request
    dc0 = done_cnt;
    set_req(16'd0, 16'd9, 16'd0, 16'd9, 16'h0F0F, 1'b0);
    pulse_start();
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_cs", 32'(bus.disp_cs), 32'd1);
    chk("t6_rst_valid", 32'(bus.data_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    chk("t6_no_done", 32'(done_cnt - dc0), 32'd0);
    base = got.size();
    set_req(16'd1, 16'd1, 16'd2, 16'd2, 16'hFFFF, 1'b1);
    pulse_start();
    wait_done("t6", 200, 1'b0);
    exp_q = '{9'h03A, 9'h166, 9'h02A, 9'h100, 9'h101, 9'h100, 9'h101, 9'h02B,
              9'h100, 9'h102, 9'h100, 9'h102, 9'h02C, 9'h1FC, 9'h1FC, 9'h1FC};
    cmp_stream("t6", base);
    chk_idle("t6_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
